// File: rtl/waveform_plot_if.sv
// rtl/waveform_plot_if.sv - CODEC read handshake and vga_adapter plot bus for waveform_plot_ctrl
interface waveform_plot_if;
  logic        enable;
  logic        sample_valid;
  logic [23:0] sample_data;
  logic        sample_ack;
  logic        plot;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        busy;
  logic        frame_done;

  modport master (
    output enable, sample_valid, sample_data,
    input  sample_ack, plot, x, y, colour, busy, frame_done
  );

  modport slave (
    input  enable, sample_valid, sample_data,
    output sample_ack, plot, x, y, colour, busy, frame_done
  );
endinterface

// File: rtl/waveform_plot_ctrl.sv
// rtl/waveform_plot_ctrl.sv - decimating CODEC-to-VGA oscilloscope column scheduler
// Optional PLOT_LINE_EN: join consecutive samples with a vertical line segment.
module waveform_plot_ctrl #(
  parameter int         DECIM      = 4,
  parameter int         GAIN_SHIFT = 1,
  parameter int         Y_CENTER   = 60,
  parameter logic [2:0] COLOUR     = 3'b111
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  waveform_plot_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ERASE,
    S_PLOT,
    S_NEXT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] column_q, column_d;
  logic [7:0] decim_cnt_q, decim_cnt_d;
  logic [6:0] prev_y_q, prev_y_d;
  logic [6:0] y_new_q, y_new_d;
  logic [6:0] y_end_q, y_end_d;
  logic       plot_q, plot_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;

  logic              sample_ack;
  logic signed [9:0] s_ext, v_shift, t_val;
  logic [6:0]        y_map;
  logic [6:0]        line_lo, line_hi;
  logic              unused_bits;

  assign unused_bits = ^{bus.sample_data[15:0], prev_y_q};

  // Sample byte -> screen row, clamped to the visible 0..119 range.
  always_comb begin
    s_ext   = {{2{bus.sample_data[23]}}, bus.sample_data[23:16]};
    v_shift = s_ext >>> GAIN_SHIFT;
    t_val   = $signed(10'(Y_CENTER)) - v_shift;
    if (t_val[9]) begin
      y_map = 7'd0;
    end else if (t_val > 10'sd119) begin
      y_map = 7'd119;
    end else begin
      y_map = t_val[6:0];
    end
  end

  always_comb begin
    line_lo = y_new_q;
    line_hi = y_new_q;
`ifdef PLOT_LINE_EN
    if (column_q != 8'd0) begin
      if (prev_y_q < y_new_q) begin
        line_lo = prev_y_q;
      end else begin
        line_hi = prev_y_q;
      end
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    column_d    = column_q;
    decim_cnt_d = decim_cnt_q;
    prev_y_d    = prev_y_q;
    y_new_d     = y_new_q;
    y_end_d     = y_end_q;
    plot_d      = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    colour_d    = colour_q;
    sample_ack  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.sample_valid) begin
          sample_ack = 1'b1;
          if (decim_cnt_q == 8'(DECIM - 1)) begin
            decim_cnt_d = 8'd0;
            y_new_d     = y_map;
            state_d     = S_ERASE;
            plot_d      = 1'b1;
            x_d         = column_q;
            y_d         = 7'd0;
            colour_d    = 3'b000;
          end else begin
            decim_cnt_d = decim_cnt_q + 8'd1;
          end
        end else if (!bus.enable) begin
          state_d = S_IDLE;
        end
      end
      S_ERASE: begin
        plot_d = 1'b1;
        if (y_q != 7'd119) begin
          y_d = y_q + 7'd1;
        end else begin
          state_d  = S_PLOT;
          y_d      = line_lo;
          y_end_d  = line_hi;
          colour_d = COLOUR;
        end
      end
      S_PLOT: begin
        if (y_q != y_end_q) begin
          plot_d = 1'b1;
          y_d    = y_q + 7'd1;
        end else begin
          state_d  = S_NEXT;
          prev_y_d = y_new_q;
        end
      end
      S_NEXT: begin
        column_d = (column_q == 8'd159) ? 8'd0 : column_q + 8'd1;
        state_d  = bus.enable ? S_WAIT : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q     <= S_IDLE;
      column_q    <= 8'd0;
      decim_cnt_q <= 8'd0;
      prev_y_q    <= 7'(Y_CENTER);
      y_new_q     <= 7'd0;
      y_end_q     <= 7'd0;
      plot_q      <= 1'b0;
      x_q         <= 8'd0;
      y_q         <= 7'd0;
      colour_q    <= 3'b000;
    end else begin
      state_q     <= state_d;
      column_q    <= column_d;
      decim_cnt_q <= decim_cnt_d;
      prev_y_q    <= prev_y_d;
      y_new_q     <= y_new_d;
      y_end_q     <= y_end_d;
      plot_q      <= plot_d;
      x_q         <= x_d;
      y_q         <= y_d;
      colour_q    <= colour_d;
    end
  end

  assign bus.sample_ack = sample_ack;
  assign bus.plot       = plot_q;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.colour     = colour_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = (state_q == S_NEXT) && (column_q == 8'd159);

endmodule

// File: tb/tb_waveform_plot_ctrl.sv
// tb/tb_waveform_plot_ctrl.sv - randomized bench for waveform_plot_ctrl against a pixel-queue model
module tb_waveform_plot_ctrl;
  localparam int DECIM      = 4;
  localparam int GAIN_SHIFT = 1;
  localparam int Y_CENTER   = 60;

  logic CLOCK_50 = 1'b0;
  logic reset;
  always #10 CLOCK_50 = ~CLOCK_50;

  waveform_plot_if bus ();

  waveform_plot_ctrl #(
    .DECIM(DECIM), .GAIN_SHIFT(GAIN_SHIFT), .Y_CENTER(Y_CENTER), .COLOUR(3'b111)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bus)
  );

  typedef struct {
    bit plot;
    int x;
    int y;
    int colour;
    bit fd;
  } pix_t;

  // Model: pixels still owed for the current column, one entry per cycle,
  // closed by a plot=0 entry for the column-advance cycle.
  pix_t pend[$];
  bit   m_run;
  int   m_col, m_decim, m_prev, m_cols;

  int n_vec = 0, n_err = 0;
  bit check_en = 0;
  int fd_cnt = 0, ack_cnt = 0, white_cnt = 0, last_wx = -1, last_wy = -1;

  task automatic check(string nm, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int map_y(logic [23:0] d);
    logic signed [7:0] b;
    int s, div, v, t;
    b   = d[23:16];
    s   = int'(b);
    div = 1 << GAIN_SHIFT;
    v   = (s >= 0) ? s / div : -((-s + div - 1) / div);
    t   = Y_CENTER - v;
    if (t < 0) t = 0;
    if (t > 119) t = 119;
    return t;
  endfunction

  function automatic void build_column(int yn);
    int lo, hi;
    for (int r = 0; r < 120; r++) pend.push_back('{1'b1, m_col, r, 0, 1'b0});
    lo = yn;
    hi = yn;
`ifdef PLOT_LINE_EN
    if (m_col != 0) begin
      lo = (m_prev < yn) ? m_prev : yn;
      hi = (m_prev < yn) ? yn : m_prev;
    end
`endif
    for (int r = lo; r <= hi; r++) pend.push_back('{1'b1, m_col, r, 7, 1'b0});
    pend.push_back('{1'b0, m_col, 0, 0, (m_col == 159)});
    m_prev = yn;
  endfunction

  always @(negedge CLOCK_50) begin
    if (check_en) begin
      if (pend.size() > 0) begin
        check("plot", int'(bus.plot), int'(pend[0].plot));
        if (pend[0].plot) begin
          check("x", int'(bus.x), pend[0].x);
          check("y", int'(bus.y), pend[0].y);
          check("colour", int'(bus.colour), pend[0].colour);
        end
        check("frame_done", int'(bus.frame_done), int'(pend[0].fd));
        check("busy", int'(bus.busy), 1);
        check("sample_ack", int'(bus.sample_ack), 0);
      end else begin
        check("plot_idle", int'(bus.plot), 0);
        check("frame_done_idle", int'(bus.frame_done), 0);
        check("busy_wait", int'(bus.busy), int'(m_run));
        check("sample_ack_wait", int'(bus.sample_ack), int'(m_run && bus.sample_valid));
      end
    end
    if (bus.plot === 1'b1 && bus.colour == 3'd7) begin
      white_cnt++;
      last_wx = int'(bus.x);
      last_wy = int'(bus.y);
    end
    if (bus.frame_done === 1'b1) fd_cnt++;
    if (bus.sample_ack === 1'b1) ack_cnt++;

    if (reset) begin
      pend.delete();
      m_run = 0; m_col = 0; m_decim = 0; m_prev = Y_CENTER;
    end else if (pend.size() > 0) begin
      pix_t e;
      e = pend.pop_front();
      if (!e.plot) begin
        m_col = (m_col == 159) ? 0 : m_col + 1;
        m_cols++;
        m_run = bus.enable;
      end
    end else if (m_run) begin
      if (bus.sample_valid) begin
        if (m_decim == DECIM - 1) begin
          m_decim = 0;
          build_column(map_y(bus.sample_data));
        end else begin
          m_decim++;
        end
      end else if (!bus.enable) begin
        m_run = 0;
      end
    end else if (bus.enable) begin
      m_run = 1;
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic wait_cols(int target, int budget);
    int n = 0;
    while (m_cols < target && n < budget) begin
      tick();
      n++;
    end
    if (m_cols < target) check("wait_cols_timeout", m_cols, target);
  endtask

  task automatic kept_sample(logic [23:0] d);
    int target = m_cols + 1;
    bus.enable       = 1'b1;
    bus.sample_data  = d;
    bus.sample_valid = 1'b1;
    wait_cols(target, 2000);
    bus.sample_valid = 1'b0;
  endtask

  initial begin
    m_cols = 0;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.sample_valid = 1'b1;
    bus.sample_data = 24'h0;
    tick();
    tick();
    check("rst_plot", int'(bus.plot), 0);
    check("rst_x", int'(bus.x), 0);
    check("rst_y", int'(bus.y), 0);
    check("rst_colour", int'(bus.colour), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_frame_done", int'(bus.frame_done), 0);
    reset = 1'b0;
    check_en = 1'b1;
    ack_cnt = 0;
    repeat (5) tick();
    check("no_ack_when_disabled", ack_cnt, 0);

    kept_sample(24'h100000);
    check("col0_acks", ack_cnt, 4);
    check("col0_white_x", last_wx, 0);
    check("col0_white_y", last_wy, 52);
    kept_sample(24'h800000);
    check("col1_white_x", last_wx, 1);
    check("col1_white_y", last_wy, 119);
    kept_sample(24'h7FFFFF);
    check("col2_white_x", last_wx, 2);
    check("col2_white_y", last_wy, 0);
    check("three_col_acks", ack_cnt, 12);

    // Drop enable partway through an erase; the column must still finish.
    begin
      int n = 0;
      bus.sample_data  = 24'h080000;
      bus.sample_valid = 1'b1;
      while (bus.plot !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      if (bus.plot !== 1'b1) check("erase_start_timeout", 0, 1);
      repeat (10) tick();
      bus.enable       = 1'b0;
      bus.sample_valid = 1'b0;
      wait_cols(4, 300);
      repeat (3) tick();
      check("drop_col_x", last_wx, 3);
      check("drop_col_y", last_wy, 56);
      check("drop_idle_busy", int'(bus.busy), 0);
    end

    begin
      int n = 0;
      bus.enable = 1'b1;
      while (m_cols < 160 && n < 60000) begin
        tick();
        n++;
        bus.sample_valid = ($urandom_range(0, 9) < 6);
        bus.sample_data  = 24'($urandom);
        if ($urandom_range(0, 399) == 0) bus.enable = ~bus.enable;
        if (!bus.enable && $urandom_range(0, 19) == 0) bus.enable = 1'b1;
      end
      if (m_cols < 160) check("random_timeout", m_cols, 160);
      bus.sample_valid = 1'b0;
    end
    check("frame_done_once", fd_cnt, 1);
    kept_sample(24'h000000);
    check("wrap_white_x", last_wx, 0);
    check("wrap_white_y", last_wy, 60);

    // Reset in the middle of an erase must stop plotting at once.
    begin
      int n = 0;
      bus.sample_data  = 24'($urandom);
      bus.sample_valid = 1'b1;
      while (bus.plot !== 1'b1 && n < 100) begin
        tick();
        n++;
      end
      bus.sample_valid = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      check("midreset_plot", int'(bus.plot), 0);
      check("midreset_busy", int'(bus.busy), 0);
      reset = 1'b0;
      bus.enable = 1'b0;
      repeat (5) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
